// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO between the CPU and the external UART sender.
// The CPU pushes single bytes or little-endian 32-bit words. The FSM drains
// one byte per sender frame through the tx_start/sdata/tx_busy handshake
// while tx_enable is high.
// Optional build macro: UART_TX_OVERFLOW_EN adds a sticky overflow flag for
// pushes that arrive with wr_ready low.
module uart_tx_buffer #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_enable,
  input  logic        wr_en,
  input  logic        wr_word,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  sdata,
  output logic        empty,
  output logic        overflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] FOUR_W  = (DEPTH_LOG2 + 1)'(4);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] START   = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  logic [1:0]            state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   free;
  logic [DEPTH_LOG2:0]   push_n;
  logic                  push_ok;
  logic                  pop;

  assign free     = DEPTH_W - count;
  assign wr_ready = (free >= FOUR_W);
  assign empty    = (count == '0);
  assign push_ok  = wr_en & wr_ready;
  assign pop      = (state == IDLE) & tx_enable & ~empty & ~tx_busy;

  // Number of bytes entering the FIFO this cycle
  always_comb begin
    push_n = '0;
    if (push_ok) begin
      push_n = wr_word ? FOUR_W : (DEPTH_LOG2 + 1)'(1);
    end
  end

  // Byte RAM write: one byte or four consecutive bytes starting at wptr
  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (push_ok && (wr_word || k == 0)) begin
        mem[wptr + DEPTH_LOG2'(k)] <= wr_data[8*k +: 8];
      end
    end
  end

  // Write pointer and occupancy; a push and a pop may land on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + push_n[DEPTH_LOG2-1:0];
      count <= count + push_n - (DEPTH_LOG2 + 1)'(pop);
    end
  end

  // Drain FSM. The byte is popped on the IDLE->START edge so that tx_start
  // and sdata are registered together and sdata is valid during the pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      sdata    <= '0;
      rptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            tx_start <= 1'b1;
            sdata    <= mem[rptr];
            rptr     <= rptr + 1'b1;
          end
        end
        START: begin
          tx_start <= 1'b0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_OVERFLOW_EN
  // Sticky flag: set by any push attempted while wr_ready is low
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en && !wr_ready) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer (DEPTH_LOG2=4). A behavioural UART sender
// answers tx_start, and a byte queue holds the expected transmit order.
module tb_uart_tx_buffer;

  localparam int DL    = 4;
  localparam int DEPTH = 2 ** DL;
`ifdef UART_TX_OVERFLOW_EN
  localparam logic OVF_BUILT = 1'b1;
`else
  localparam logic OVF_BUILT = 1'b0;
`endif

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        tx_enable = 1'b0;
  logic        wr_en     = 1'b0;
  logic        wr_word   = 1'b0;
  logic [31:0] wr_data   = '0;
  logic        tx_busy   = 1'b0;
  logic        wr_ready;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        empty;
  logic        overflow;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         starts  = 0;
  int         fmin    = 2;
  int         fmax    = 12;
  bit         mon_on  = 1'b0;
  logic       ovf_exp = 1'b0;
  logic [7:0] exp_q[$];

  uart_tx_buffer #(.DEPTH_LOG2(DL)) dut (
    .clock     (clock),
    .reset     (reset),
    .tx_enable (tx_enable),
    .wr_en     (wr_en),
    .wr_word   (wr_word),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .sdata     (sdata),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural sender: captures each tx_start, stays busy for a random frame
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (tx_start === 1'b1) begin
        starts++;
        check("start_with_data", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sdata", 32'(sdata), 32'(exp_q.pop_front()));
        tx_busy = 1'b1;
        @(posedge clock);
        #1;
        check("start_pulse_len", 32'(tx_start), 32'd0);
        repeat ($urandom_range(fmax, fmin)) @(posedge clock);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  // Status outputs against the model occupancy, every cycle
  always @(negedge clock) begin
    if (mon_on) begin
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("wr_ready", 32'(wr_ready), 32'((DEPTH - exp_q.size()) >= 4));
      check("overflow", 32'(overflow), 32'(ovf_exp));
    end
  end

  // One clock of stimulus; the model decides acceptance from its own occupancy
  task automatic step(input logic en, input logic word, input logic [31:0] data);
    bit acc;
    wr_en   = en;
    wr_word = word;
    wr_data = data;
    acc = en && ((DEPTH - exp_q.size()) >= 4);
    @(posedge clock);
    if (acc) begin
      exp_q.push_back(data[7:0]);
      if (word) begin
        exp_q.push_back(data[15:8]);
        exp_q.push_back(data[23:16]);
        exp_q.push_back(data[31:24]);
      end
    end else if (en && OVF_BUILT) begin
      ovf_exp = 1'b1;
    end
    #2;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    n = 0;
    while (tx_busy && n < budget) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    check("busy_timeout", 32'(tx_busy), 32'd0);
    repeat (3) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;

    // Reset state
    repeat (3) @(posedge clock);
    #2;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Word push drains as four bytes, low byte first
    tx_enable = 1'b1;
    s0 = starts;
    step(1'b1, 1'b1, 32'h4433_2211);
    wait_drain(500);
    check("word_starts", 32'(starts - s0), 32'd4);

    // Draining gated by tx_enable
    tx_enable = 1'b0;
    step(1'b1, 1'b0, 32'h0000_00AB);
    s0 = starts;
    repeat (100) step(1'b0, 1'b0, '0);
    check("gated_no_start", 32'(starts - s0), 32'd0);
    check("gated_empty", 32'(empty), 32'd0);
    tx_enable = 1'b1;
    wait_drain(500);
    check("gated_one_start", 32'(starts - s0), 32'd1);

    // Fill completely (pointers wrap), then drop a word and a byte
    tx_enable = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h0302_0100 + 32'(i) * 32'h0404_0404);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'h0000_005A);
    check("full_overflow", 32'(overflow), 32'(OVF_BUILT));
    tx_enable = 1'b1;
    n = 0;
    while (exp_q.size() > DEPTH - 4 && n < 500) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    check("refill_ready", 32'(wr_ready), 32'd1);
    step(1'b1, 1'b1, 32'h1B1A_1918);
    wait_drain(1000);

    // Byte push dropped with only 3 bytes free
    tx_enable = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'hC3C2_C1C0 + 32'(i) * 32'h0404_0404);
    step(1'b1, 1'b0, 32'h0000_00CC);
    check("free3_wr_ready", 32'(wr_ready), 32'd0);
    step(1'b1, 1'b0, 32'h0000_00EE);
    tx_enable = 1'b1;
    wait_drain(1000);

    // Push on the same edge as a pop with 5 bytes queued
    tx_enable = 1'b0;
    step(1'b1, 1'b1, 32'h1514_1312);
    step(1'b1, 1'b0, 32'h0000_0016);
    tx_enable = 1'b1;
    step(1'b1, 1'b0, 32'h0000_0017);
    check("simul_start", 32'(tx_start), 32'd1);
    wait_drain(1000);

    // Randomized traffic with enable toggling and short frames
    fmin = 1;
    fmax = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15, 0) == 0) tx_enable = ~tx_enable;
      step($urandom_range(2, 0) == 0, 1'($urandom_range(1, 0)), $urandom());
    end
    tx_enable = 1'b1;
    wait_drain(5000);

    // Reset during WAIT_LO with 3 bytes still queued
    fmin = 30;
    fmax = 30;
    step(1'b1, 1'b1, 32'h2423_2221);
    s0 = starts;
    n = 0;
    while (starts == s0 && n < 100) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    check("rst_first_start", 32'(starts - s0), 32'd1);
    repeat (3) step(1'b0, 1'b0, '0);
    check("rst_queued", 32'(exp_q.size()), 32'd3);
    reset = 1'b1;
    @(posedge clock);
    exp_q.delete();
    ovf_exp = 1'b0;
    #2;
    check("rst_mid_empty", 32'(empty), 32'd1);
    check("rst_mid_tx_start", 32'(tx_start), 32'd0);
    reset = 1'b0;
    s0 = starts;
    repeat (60) step(1'b0, 1'b0, '0);
    check("rst_no_start", 32'(starts - s0), 32'd0);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Output path from the CPU to the PC over UART; the mirror of the loader's receive path.
- The CPU pushes single bytes or 32-bit words (little-endian) into a byte FIFO.
- The block drains the FIFO one byte at a time into the external UART sender via the tx_start/sdata/tx_busy handshake.
- Draining is gated by tx_enable, tied to program_loaded, so the loader's 0x99/0xaa bytes always own the sender first.

Parameters:
- DEPTH_LOG2, 6, FIFO depth is 2**DEPTH_LOG2 bytes; minimum 2.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tx_enable  input  1  1 = draining allowed (connect program_loaded)
- wr_en  input  1  push request, sampled on the rising edge
- wr_word  input  1  1 = push 4 bytes of wr_data; 0 = push wr_data[7:0] only
- wr_data  input  32  write data; byte 0 (bits [7:0]) is sent first
- wr_ready  output  1  1 when free space is at least 4 bytes
- tx_busy  input  1  UART sender busy
- tx_start  output  1  one-cycle start pulse to the sender
- sdata  output  8  byte to send; valid while tx_start=1
- empty  output  1  FIFO count is 0
- overflow  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset values: tx_start=0, sdata=0, overflow=0, FSM=IDLE, read/write pointers=0, count=0. Outputs are therefore empty=1 and wr_ready=1.
- Reset mid-transfer aborts the transfer and drops all queued bytes. No further tx_start is issued until new data arrives.
- Storage:
  - Byte RAM with DEPTH_LOG2-bit pointers that wrap modulo 2**DEPTH_LOG2.
  - count is DEPTH_LOG2+1 bits.
  - free = 2**DEPTH_LOG2 - count.
- Push (edge where wr_en=1):
  - Accepted only if wr_ready=1.
  - wr_word=1: bytes [7:0],[15:8],[23:16],[31:24] are written at wptr..wptr+3; wptr += 4; count += 4.
  - wr_word=0: [7:0] is written at wptr; wptr += 1; count += 1.
  - A push with wr_ready=0 is dropped and FIFO contents are unchanged, even for a byte push when 1..3 bytes are free.
- wr_ready and empty are combinational from the registered count. A push is visible in empty on the next cycle.
- FSM states:
  - IDLE: if tx_enable=1 and count!=0 and tx_busy=0, go to START.
  - START: tx_start=1 for exactly one cycle; sdata = RAM[rptr]; rptr += 1; count -= 1; go to WAIT_HI.
  - WAIT_HI: stay until tx_busy=1, then go to WAIT_LO. The sender raises tx_busy the cycle after tx_start.
  - WAIT_LO: stay until tx_busy=0, then go to IDLE.
- Simultaneous push and pop in the same cycle: count += pushed - 1. wr_ready uses the pre-update count.
- tx_enable falling mid-byte does not abort that byte. It only blocks the next IDLE->START.
- Throughput: at most one byte per sender frame plus 2 cycles of overhead.
- sdata holds its last value outside START.

Optional Feature:
- Macro: UART_TX_OVERFLOW_EN.
- Defined: overflow goes to 1 on the edge after any wr_en=1 with wr_ready=0. It stays 1 until reset.
- Undefined: overflow is tied to 0 and no detection logic is built. Dropped pushes are silent.

Test Plan:
- tx_enable=1, push word 0x44332211 -> tx_start pulses four times with sdata 0x11, 0x22, 0x33, 0x44 in order. Each pulse follows tx_busy falling. empty=1 after the fourth START.
- tx_enable=0, push byte 0xAB -> no tx_start for 100 cycles and empty=0. Raise tx_enable -> one tx_start with sdata=0xAB.
- DEPTH_LOG2=3, tx_enable=0, push words 0x03020100 and 0x07060504 -> wr_ready=0. Enable -> bytes 0x00..0x07 are sent in order, covering pointer wrap. A third word is then accepted once free is at least 4.
- With FIFO full, push 0xDEADBEEF -> contents unchanged. overflow=1 with UART_TX_OVERFLOW_EN defined; overflow=0 without it.
- Push a byte in the same cycle as a START pop with count=5 -> count stays 5. Byte order is preserved.
- Assert reset during WAIT_LO with 3 bytes queued -> next cycle empty=1, tx_start=0. After release, no tx_start occurs.
